// File: rtl/vec3_mul_arbiter_pkg.sv
// Shared types for the vec3 multiply arbiter slice.
//   fixed_t : signed Q7.8 fixed-point component
//   vec3_t  : packed {x, y, z} of fixed_t
//   req_id_w: width of a requester index for a given requester count
//   fx_mul / vec3_mul: fixed-point products, low fraction bits dropped
package vec3_mul_arbiter_pkg;

   localparam int unsigned COMP_W = 16;
   localparam int unsigned FRAC_W = 8;

   typedef logic signed [COMP_W-1:0] fixed_t;

   typedef struct packed {
      fixed_t x;
      fixed_t y;
      fixed_t z;
   } vec3_t;

   function automatic int unsigned req_id_w(int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Full-width signed product, then keep the COMP_W bits above the fraction (floor rounding).
   function automatic fixed_t fx_mul(fixed_t a, fixed_t b);
      logic signed [2*COMP_W-1:0] p;
      p = a * b;
      return fixed_t'(p[FRAC_W +: COMP_W]);
   endfunction

   function automatic vec3_t vec3_mul(vec3_t a, vec3_t b);
      vec3_t r;
      r.x = fx_mul(a.x, b.x);
      r.y = fx_mul(a.y, b.y);
      r.z = fx_mul(a.z, b.z);
      return r;
   endfunction

endpackage

// File: rtl/mul_vec3.sv
// Element-wise vec3 fixed-point multiplier, LATENCY register stages.
//   clk, rst        : clock, synchronous active-high reset
//   din_valid, a, b : operands, accepted whenever din_valid=1
//   dout_valid, dout: product LATENCY cycles later; dout holds when no new product
module mul_vec3
   import vec3_mul_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  din_valid,
   input  vec3_t a,
   input  vec3_t b,
   output logic  dout_valid,
   output vec3_t dout
);

   logic [LATENCY-1:0] vld_q;
   vec3_t              dat_q [LATENCY];

   // Data stages only load on valid so the output holds its last product.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int s = 0; s < LATENCY; s++) dat_q[s] <= '0;
      end else begin
         vld_q[0] <= din_valid;
         if (din_valid) dat_q[0] <= vec3_mul(a, b);
         for (int s = 1; s < LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
         end
      end
   end

   assign dout_valid = vld_q[LATENCY-1];
   assign dout       = dat_q[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with internal pointer.
//   req     : request vector
//   en      : 0 forces an all-zero grant
//   advance : a grant was accepted; pointer moves past the granted index
//   grant   : one-hot grant (combinational)
//   idx     : index of the granted requester (0 when none)
module rr_arbiter
   import vec3_mul_arbiter_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic                   en,
   input  logic                   advance,
   output logic [N-1:0]           grant,
   output logic [req_id_w(N)-1:0] idx
);

   localparam int unsigned IdW = req_id_w(N);

   logic [IdW-1:0] ptr_q;
   logic [IdW-1:0] ptr_d;
   logic           found;

   // First asserted request at or after the pointer, wrapping mod N.
   always_comb begin
      int unsigned j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (int'(ptr_q) + k) % N;
         if (!found && en && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IdW'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/vec3_mul_arbiter.sv
// Shares one mul_vec3 among N_REQ requesters with round-robin issue and returns
// each product to its owner via an id pipe aligned with the multiplier.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 1 allows new grants, 0 drains in-flight work only
//   req_valid  : per-requester operand valid
//   req_ready  : one-hot grant, handshake = valid & ready
//   req_a/b    : per-requester operands
//   resp_valid : one-hot 1-cycle pulse to the product owner
//   resp_data  : product (held when no response)
//   resp_id    : owner index of resp_data (held when no response)
//   idle       : no grant this cycle and nothing in flight
module vec3_mul_arbiter
   import vec3_mul_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned MUL_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  vec3_t [N_REQ-1:0]          req_a,
   input  vec3_t [N_REQ-1:0]          req_b,
   output logic [N_REQ-1:0]           resp_valid,
   output vec3_t                      resp_data,
   output logic [req_id_w(N_REQ)-1:0] resp_id,
   output logic                       idle
);

   localparam int unsigned IdW = req_id_w(N_REQ);

   logic [N_REQ-1:0]       grant;
   logic [IdW-1:0]         gidx;
   logic                   hs;
   vec3_t                  sel_a;
   vec3_t                  sel_b;
   logic                   dout_valid;
   vec3_t                  dout;
   logic [MUL_LATENCY-1:0] pv_q;
   logic [IdW-1:0]         pid_q [MUL_LATENCY];

   // Grants are suppressed during reset so req_ready reads 0 there.
   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .en      (en & ~rst),
      .advance (hs),
      .grant   (grant),
      .idx     (gidx)
   );

   assign req_ready = grant;
   assign hs        = |grant;
   assign sel_a     = req_a[gidx];
   assign sel_b     = req_b[gidx];

   mul_vec3 #(
      .LATENCY (MUL_LATENCY)
   ) u_mul (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (hs),
      .a          (sel_a),
      .b          (sel_b),
      .dout_valid (dout_valid),
      .dout       (dout)
   );

   // Id stages load only behind a valid entry so the output id holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q <= '0;
         for (int s = 0; s < MUL_LATENCY; s++) pid_q[s] <= '0;
      end else begin
         pv_q[0] <= hs;
         if (hs) pid_q[0] <= gidx;
         for (int s = 1; s < MUL_LATENCY; s++) begin
            pv_q[s] <= pv_q[s-1];
            if (pv_q[s-1]) pid_q[s] <= pid_q[s-1];
         end
      end
   end

   // Masking with rst drops a product that is at the output when reset arrives.
   always_comb begin
      resp_valid = '0;
      if (dout_valid && !rst) resp_valid[pid_q[MUL_LATENCY-1]] = 1'b1;
   end

   assign resp_id   = pid_q[MUL_LATENCY-1];
   assign resp_data = dout;
   assign idle      = rst | (~hs & ~(|pv_q));

   a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));
   a_resp_onehot  : assert property (@(posedge clk) $onehot0(resp_valid));
   a_lat_align    : assert property (@(posedge clk) disable iff (rst)
                                     dout_valid == pv_q[MUL_LATENCY-1])
      else $error("mul_vec3 latency does not match MUL_LATENCY");

endmodule

// File: tb/tb_vec3_mul_arbiter.sv
module tb_vec3_mul_arbiter;
   import vec3_mul_arbiter_pkg::*;

   localparam int N = 4;
   localparam int L = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   vec3_t [N-1:0]    req_a;
   vec3_t [N-1:0]    req_b;
   logic [N-1:0]     resp_valid;
   vec3_t            resp_data;
   logic [1:0]       resp_id;
   logic             idle;

   always #5 clk = ~clk;

   vec3_mul_arbiter #(
      .N_REQ       (N),
      .MUL_LATENCY (L)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .idle       (idle)
   );

   typedef struct {
      int    id;
      vec3_t data;
      int    due;
   } exp_t;

   exp_t  sbq[$];
   int    checks  = 0;
   int    errors  = 0;
   int    cyc     = 0;
   int    mptr    = 0;
   int    last_hs = -100;
   vec3_t last_data;
   int    last_id;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference product: real-valued product scaled by 256, floored, wrapped to 16 bits.
   function automatic fixed_t fxm(fixed_t a, fixed_t b);
      int          p;
      logic [31:0] s;
      p = int'(a) * int'(b);
      s = p >>> 8;
      return fixed_t'(s[15:0]);
   endfunction

   function automatic vec3_t vmul(vec3_t a, vec3_t b);
      vec3_t r;
      r.x = fxm(a.x, b.x);
      r.y = fxm(a.y, b.y);
      r.z = fxm(a.z, b.z);
      return r;
   endfunction

   task automatic rand_ops();
      logic [63:0] r;
      for (int i = 0; i < N; i++) begin
         r = {$urandom(), $urandom()};
         req_a[i] = r[47:0];
         r = {$urandom(), $urandom()};
         req_b[i] = r[47:0];
      end
   endtask

   // Model one cycle with the inputs currently applied, then advance to the next cycle.
   task automatic step();
      int            g;
      logic [N-1:0]  exp_rdy;
      logic          inflight;
      @(negedge clk);
      g       = -1;
      exp_rdy = '0;
      if (!rst && en) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      inflight = (last_hs < cyc) && (last_hs >= cyc - L);
      chk("req_ready", req_ready, exp_rdy);
      chk("idle", idle, rst || (g < 0 && !inflight));
      if (rst) begin
         mptr    = 0;
         last_hs = -100;
         sbq.delete();
      end else if (g >= 0) begin
         sbq.push_back('{g, vmul(req_a[g], req_b[g]), cyc + L});
         mptr    = (g + 1) % N;
         last_hs = cyc;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever a response appears or one is overdue.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("resp_valid_in_reset", resp_valid, 0);
         last_data = '0;
         last_id   = 0;
      end else if (resp_valid != 0) begin
         if (sbq.size() == 0) begin
            chk("unexpected_resp", resp_valid, 0);
         end else begin
            e = sbq.pop_front();
            chk("resp_valid", resp_valid, 64'(1) << e.id);
            chk("resp_id", resp_id, e.id);
            chk("resp_data", resp_data, e.data);
            chk("resp_latency", cyc, e.due);
            last_data = e.data;
            last_id   = e.id;
         end
      end else begin
         chk("resp_data_hold", resp_data, last_data);
         chk("resp_id_hold", resp_id, last_id);
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("missing_resp", resp_valid, 64'(1) << e.id);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      req_valid = '1;
      rand_ops();
      // Reset held with all requesting, then first grant goes to 0.
      repeat (3) step();
      rst = 1'b0;
      step();

      // Single request from requester 1.
      do_reset();
      req_valid = 4'b0010;
      req_a[1]  = '{16'sh0100, 16'sh0200, 16'shFD00};
      req_b[1]  = '{16'sh0200, 16'sh0080, 16'sh0100};
      step();
      req_valid = '0;
      repeat (2) step();
      chk("single_product", last_data, {16'h0200, 16'h0100, 16'hFD00});

      // All valid for 8 cycles.
      do_reset();
      req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         step();
      end
      req_valid = '0;
      repeat (2) step();

      // Sparse requests around the wrap.
      do_reset();
      req_valid = 4'b1000;
      step();
      req_valid = 4'b0101;
      step();
      step();
      req_valid = '0;
      repeat (2) step();

      // Drain: en drops after 2 grants.
      do_reset();
      req_valid = '1;
      rand_ops();
      repeat (2) step();
      en = 1'b0;
      repeat (4) step();
      en = 1'b1;

      // Reset with one product in flight.
      do_reset();
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      rst       = 1'b1;
      step();
      rst       = 1'b0;
      step();
      req_valid = '1;
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         req_valid = N'($urandom());
         en        = ($urandom_range(0, 7) != 0);
         rand_ops();
         if ($urandom_range(0, 99) == 0) rst = 1'b1;
         else rst = 1'b0;
         step();
      end
      rst       = 1'b0;
      en        = 1'b0;
      req_valid = '0;
      repeat (L + 3) step();
      chk("scoreboard_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
